i2c_write_master: RTL
=====================

// Module: i2c_write_master
// PURPOSE
//  Parametrised I2C write master (SCL generation, START/ADDR/DATA/ACK/STOP sequencing, SDA drive/tri-state).
//  Generalises the fixed two-data-byte output logic to 0..MAX_BYTES data bytes, with a programmable SCL rate.
//  Sits between the codec/sensor config sequencer and the SDA/SCL pads. SDA pad: drive i2c_sdat when ts=1, else Z.
// PARAMETERS
//  CLK_DIV    125  clk cycles per SCL quarter-period (>=2); SCL = f_clk/(4*CLK_DIV); 50 MHz -> 100 kHz
//  MAX_BYTES  2    max data bytes per transaction (>=1); sizes wr_data and num_bytes
// PORTS
//  clk         in   1              system clock; everything on rising edge
//  reset       in   1              synchronous, active-high reset
//  start       in   1              request transaction; sampled only in IDLE
//  dev_addr    in   7              7-bit slave address; R/W bit always 0 (write)
//  num_bytes   in   $clog2(MAX_BYTES+1)  data bytes to send, 0..MAX_BYTES
//  wr_data     in   8*MAX_BYTES    byte k = wr_data[8k+7:8k]; byte 0 sent first, MSB first
//  i2c_sdat_in in   1              SDA pad input (for ACK sampling)
//  i2c_sclk    out  1              SCL (push-pull)
//  i2c_sdat    out  1              SDA drive value
//  ts          out  1              1 = drive SDA, 0 = release SDA (Z)
//  busy        out  1              high from accepted start until done
//  done        out  1              one-cycle pulse at transaction end
//  ack_err     out  1              sticky NACK flag; cleared on next accepted start
// BEHAVIOUR
//  Reset: IDLE, i2c_sclk=1, i2c_sdat=1, ts=0, busy=0, done=0, ack_err=0, counters=0.
//  Timing: quarter tick every CLK_DIV clk; each bit slot = 4 quarters Q0..Q3.
//   data/ack slot: SCL low in Q0,Q1, high in Q2,Q3; SDA changes only at Q0 start; ACK sampled at Q3 start.
//  FSM: IDLE->START->ADDR->ACK_A->{DATA->ACK_D}x num_bytes ->STOP->IDLE.
//   IDLE : SCL=1, SDA=1, ts=0. start=1 -> latch dev_addr/num_bytes/wr_data, busy=1, clear ack_err, go START.
//   START: ts=1; Q0,Q1 SDA=1 SCL=1; Q2,Q3 SDA=0 SCL=1 (SDA falls with SCL high).
//   ADDR : 8 slots, bits {dev_addr,1'b0} MSB first, ts=1.
//   ACK_A/ACK_D: 1 slot, ts=0; i2c_sdat_in=1 at Q3 = NACK.
//   DATA : 8 slots of current byte; byte index increments after its ACK_D.
//   STOP : ts=1; Q0,Q1 SDA=0 SCL=0->Q1 SCL=1; Q2,Q3 SDA=1 SCL=1 (SDA rises with SCL high).
//   After STOP Q3: next cycle IDLE, busy=0, done=1 for exactly one cycle.
//  num_bytes=0: address-only (START,ADDR,ACK_A,STOP). num_bytes>MAX_BYTES: clamp to MAX_BYTES.
//  Latency: accepted start -> done = 4*CLK_DIV*(11+9*n) clk cycles, n = effective byte count.
//  start while busy: ignored, no queueing. start in the same cycle as done: accepted (IDLE already).
//  Inputs changed mid-transaction: no effect (latched copy used).
//  reset mid-transaction: next edge -> reset values; no STOP generated; done not pulsed.
//  Quarter divider free-runs only while busy; restarts at 0 on each accepted start.
// CONFIGURATION
//  I2C_ACK_CHECK_EN defined: NACK in any ACK slot sets ack_err=1 and jumps to STOP at the next slot
//   boundary (remaining bytes skipped); done still pulses; latency shortens accordingly.
//  I2C_ACK_CHECK_EN undefined: ACK slots still released (ts=0) but i2c_sdat_in ignored;
//   ack_err tied 0; full sequence always sent.
// TESTING
//  T1 reset: reset=1 2 cycles -> sclk=1 sdat=1 ts=0 busy=0 done=0 ack_err=0.
//  T2 CLK_DIV=4, dev_addr=7'h1A, num_bytes=2, wr_data=16'h3C5A, slave ACKs -> SDA bits 0x34,0x5A,0x3C; done at cycle 464; ack_err=0.
//  T3 num_bytes=0, dev_addr=7'h50 -> START, 0xA0, ACK, STOP only; done at 4*4*11=176 cycles.
//  T4 (ACK_CHECK_EN) slave NACKs address -> ack_err=1, STOP after ACK_A, done at 4*4*11=176; without macro done at 464, ack_err=0.
//  T5 start pulsed again at cycle 100 while busy -> ignored, single done; reset at cycle 200 -> IDLE values next cycle, no done.
//  T6 protocol monitor throughout: SDA never changes while SCL high except START fall / STOP rise; ts=0 in every ACK slot.

Source files
------------

// File: rtl/i2c_write_master.sv
// rtl/i2c_write_master.sv - I2C write master: START, address, 0..MAX_BYTES data bytes with ACK slots, STOP.
// Define I2C_ACK_CHECK_EN to abort to STOP on a NACK and report it on ack_err.
module i2c_write_master #(
  parameter int CLK_DIV   = 125,
  parameter int MAX_BYTES = 2,
  localparam int CNT_W    = $clog2(MAX_BYTES + 1),
  localparam int DIV_W    = $clog2(CLK_DIV)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [6:0]             dev_addr,
  input  logic [CNT_W-1:0]       num_bytes,
  input  logic [8*MAX_BYTES-1:0] wr_data,
  input  logic                   i2c_sdat_in,
  output logic                   i2c_sclk,
  output logic                   i2c_sdat,
  output logic                   ts,
  output logic                   busy,
  output logic                   done,
  output logic                   ack_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_ACK_A, S_DATA, S_ACK_D, S_STOP
  } state_t;

`ifdef I2C_ACK_CHECK_EN
  localparam logic ACK_CHECK = 1'b1;
`else
  localparam logic ACK_CHECK = 1'b0;
`endif

  state_t                 state_q, state_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [1:0]             qtr_q, qtr_d;
  logic [2:0]             bit_q, bit_d;
  logic [CNT_W-1:0]       byte_q, byte_d;
  logic [CNT_W-1:0]       nbytes_q, nbytes_d;
  logic [6:0]             addr_q, addr_d;
  logic [8*MAX_BYTES-1:0] data_q, data_d;
  logic                   nack_q, nack_d;
  logic                   ack_err_q, ack_err_d;
  logic                   done_q, done_d;

  logic       tick;
  logic       slot_end;
  logic       nack_stop;
  logic [7:0] tx_byte;

  assign tick      = (div_q == DIV_W'(CLK_DIV - 1));
  assign slot_end  = tick && (qtr_q == 2'd3);
  assign nack_stop = ACK_CHECK & nack_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      qtr_q     <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      nbytes_q  <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      nack_q    <= 1'b0;
      ack_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      nbytes_q  <= nbytes_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      nack_q    <= nack_d;
      ack_err_q <= ack_err_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    nbytes_d  = nbytes_q;
    addr_d    = addr_q;
    data_d    = data_q;
    nack_d    = nack_q;
    ack_err_d = ack_err_q;
    done_d    = 1'b0;

    if (state_q == S_IDLE) begin
      div_d = '0;
      qtr_d = '0;
      if (start) begin
        addr_d    = dev_addr;
        data_d    = wr_data;
        nbytes_d  = (num_bytes > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : num_bytes;
        bit_d     = '0;
        byte_d    = '0;
        nack_d    = 1'b0;
        ack_err_d = 1'b0;
        state_d   = S_START;
      end
    end else begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
      if (tick) qtr_d = qtr_q + 2'd1;
      // ACK bit is captured as the slot enters Q3, mid SCL-high
      if (tick && qtr_q == 2'd2) nack_d = i2c_sdat_in;

      if (slot_end) begin
        case (state_q)
          S_START: begin
            bit_d   = '0;
            state_d = S_ADDR;
          end
          S_ADDR: begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = S_ACK_A;
          end
          S_ACK_A: begin
            if (nack_stop) begin
              ack_err_d = 1'b1;
              state_d   = S_STOP;
            end else if (nbytes_q == '0) begin
              state_d = S_STOP;
            end else begin
              bit_d   = '0;
              byte_d  = '0;
              state_d = S_DATA;
            end
          end
          S_DATA: begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = S_ACK_D;
          end
          S_ACK_D: begin
            if (nack_stop) begin
              ack_err_d = 1'b1;
              state_d   = S_STOP;
            end else if (byte_q + CNT_W'(1) == nbytes_q) begin
              state_d = S_STOP;
            end else begin
              byte_d  = byte_q + CNT_W'(1);
              data_d  = data_q >> 8;
              bit_d   = '0;
              state_d = S_DATA;
            end
          end
          S_STOP: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // The current data byte always sits in the low 8 bits; it shifts down after each ACK
  assign tx_byte = (state_q == S_ADDR) ? {addr_q, 1'b0} : data_q[7:0];

  always_comb begin
    i2c_sclk = 1'b1;
    i2c_sdat = 1'b1;
    ts       = 1'b0;
    case (state_q)
      S_START: begin
        ts       = 1'b1;
        i2c_sdat = ~qtr_q[1];
      end
      S_ADDR, S_DATA: begin
        ts       = 1'b1;
        i2c_sclk = qtr_q[1];
        i2c_sdat = tx_byte[3'd7 - bit_q];
      end
      S_ACK_A, S_ACK_D: begin
        i2c_sclk = qtr_q[1];
      end
      S_STOP: begin
        ts       = 1'b1;
        i2c_sclk = (qtr_q != 2'd0);
        i2c_sdat = qtr_q[1];
      end
      default: ;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign ack_err = ack_err_q;

endmodule
